// File: rtl/lcd_char_driver.sv
// lcd_char_driver: HD44780-style 4-bit writer; power-up init, then 2x16 characters from a shadowed string.
// Latency: a refresh seen in IDLE starts the 0x80 address command on the next cycle; nibbles are paced by the wait parameters.
// Backpressure: none; refreshes arriving while busy merge into one pending request that is served at frame end.
module lcd_char_driver #(
    parameter int unsigned POWERUP_CYC    = 750000,
    parameter int unsigned E_HIGH_CYC     = 12,
    parameter int unsigned NIB_GAP_CYC    = 50,
    parameter int unsigned CMD_WAIT_CYC   = 2000,
    parameter int unsigned CLR_WAIT_CYC   = 82000,
    parameter int unsigned INIT3_WAIT_CYC = 205000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [255:0] strdata,
    input  logic         refresh,
    output logic         lcd_e,
    output logic         lcd_rs,
    output logic         lcd_rw,
    output logic [3:0]   lcd_dat,
    output logic         busy,
    output logic         frame_done
);

    localparam logic [2:0] PWR_WAIT = 3'd0;
    localparam logic [2:0] INIT_NIB = 3'd1;
    localparam logic [2:0] INIT_CMD = 3'd2;
    localparam logic [2:0] ADDR1    = 3'd3;
    localparam logic [2:0] LINE1    = 3'd4;
    localparam logic [2:0] ADDR2    = 3'd5;
    localparam logic [2:0] LINE2    = 3'd6;
    localparam logic [2:0] IDLE     = 3'd7;

    // Per-nibble phases: data setup with e low, e high, then hold/gap/post-byte wait with e low.
    localparam logic [1:0] PH_SETUP = 2'd0;
    localparam logic [1:0] PH_EHI   = 2'd1;
    localparam logic [1:0] PH_WAIT  = 2'd2;

    logic [2:0]   state_q, state_d;
    logic [3:0]   idx_q, idx_d;
    logic         nib_q, nib_d;
    logic [1:0]   ph_q, ph_d;
    logic [31:0]  cnt_q, cnt_d;
    logic         e_q, e_d;
    logic         rs_q, rs_d;
    logic [3:0]   dat_q, dat_d;
    logic [255:0] shadow_q, shadow_d;
    logic         pend_q, pend_d;
    logic         fd_q, fd_d;

    logic         single;
    logic [31:0]  wait_cyc;
    logic         start;
    logic [2:0]   start_st;
    logic [3:0]   start_idx;

    // Nibble (high or low half) of the byte that item (st, idx) puts on the bus.
    // Init nibbles are stored in the high half so they go out as the "high" nibble.
    function automatic logic [3:0] item_nib(input logic [2:0] st, input logic [3:0] idx,
                                            input logic [255:0] sh, input logic hi);
        logic [7:0] pos;
        logic [7:0] b;
        pos = 8'd0;
        b   = 8'h00;
        case (st)
            INIT_NIB: b = (idx == 4'd3) ? 8'h20 : 8'h30;
            INIT_CMD: begin
                case (idx)
                    4'd0:    b = 8'h28;
                    4'd1:    b = 8'h06;
                    4'd2:    b = 8'h0C;
                    default: b = 8'h01;
                endcase
            end
            ADDR1:    b = 8'h80;
            ADDR2:    b = 8'hC0;
            LINE1, LINE2: begin
                pos = {(st == LINE2), idx, 3'b000};
                b   = sh[8'd255 - pos -: 8];
            end
            default:  b = 8'h00;
        endcase
        return hi ? b[7:4] : b[3:0];
    endfunction

    // Wait after the last nibble of an item; the clear command needs the long one.
    function automatic logic [31:0] post_wait(input logic [2:0] st, input logic [3:0] idx);
        logic [31:0] w;
        w = 32'(CMD_WAIT_CYC);
        if (st == INIT_NIB && idx == 4'd0) w = 32'(INIT3_WAIT_CYC);
        if (st == INIT_NIB && idx == 4'd1) w = 32'd5000;
        if (st == INIT_CMD && idx == 4'd3) w = 32'(CLR_WAIT_CYC);
        return w;
    endfunction

    // Next-state logic: nibble pacing, item sequencing, shadow capture and pending refresh.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        nib_d     = nib_q;
        ph_d      = ph_q;
        cnt_d     = cnt_q;
        e_d       = e_q;
        rs_d      = rs_q;
        dat_d     = dat_q;
        shadow_d  = shadow_q;
        pend_d    = pend_q | (refresh & (state_q != IDLE));
        fd_d      = 1'b0;
        start     = 1'b0;
        start_st  = state_q;
        start_idx = 4'd0;
        single    = (state_q == INIT_NIB);
        wait_cyc  = (!single && !nib_q) ? 32'(NIB_GAP_CYC) : post_wait(state_q, idx_q);

        case (state_q)
            PWR_WAIT: begin
                if (cnt_q + 32'd1 >= 32'(POWERUP_CYC)) begin
                    start    = 1'b1;
                    start_st = INIT_NIB;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            IDLE: begin
                if (refresh) begin
                    start    = 1'b1;
                    start_st = ADDR1;
                    pend_d   = 1'b0;
                end
            end
            default: begin
                case (ph_q)
                    PH_SETUP: begin
                        if (cnt_q >= 32'd1) begin
                            e_d   = 1'b1;
                            ph_d  = PH_EHI;
                            cnt_d = 32'd0;
                        end else begin
                            cnt_d = cnt_q + 32'd1;
                        end
                    end
                    PH_EHI: begin
                        if (cnt_q + 32'd1 >= 32'(E_HIGH_CYC)) begin
                            e_d   = 1'b0;
                            ph_d  = PH_WAIT;
                            cnt_d = 32'd0;
                        end else begin
                            cnt_d = cnt_q + 32'd1;
                        end
                    end
                    default: begin
                        if (cnt_q + 32'd1 < wait_cyc) begin
                            cnt_d = cnt_q + 32'd1;
                        end else if (!single && !nib_q) begin
                            // Low nibble of the same byte; rs is unchanged.
                            nib_d = 1'b1;
                            dat_d = item_nib(state_q, idx_q, shadow_q, 1'b0);
                            ph_d  = PH_SETUP;
                            cnt_d = 32'd0;
                        end else begin
                            start = 1'b1;
                            case (state_q)
                                INIT_NIB: begin
                                    start_st  = (idx_q == 4'd3) ? INIT_CMD : INIT_NIB;
                                    start_idx = (idx_q == 4'd3) ? 4'd0 : idx_q + 4'd1;
                                end
                                INIT_CMD: begin
                                    start_st  = (idx_q == 4'd3) ? ADDR1 : INIT_CMD;
                                    start_idx = (idx_q == 4'd3) ? 4'd0 : idx_q + 4'd1;
                                end
                                ADDR1:    start_st = LINE1;
                                LINE1: begin
                                    start_st  = (idx_q == 4'd15) ? ADDR2 : LINE1;
                                    start_idx = (idx_q == 4'd15) ? 4'd0 : idx_q + 4'd1;
                                end
                                ADDR2:    start_st = LINE2;
                                default: begin
                                    if (idx_q != 4'd15) begin
                                        start_idx = idx_q + 4'd1;
                                    end else begin
                                        // Frame end: a merged pending request restarts at once.
                                        fd_d     = 1'b1;
                                        pend_d   = 1'b0;
                                        start    = pend_q | refresh;
                                        start_st = ADDR1;
                                        if (!(pend_q | refresh)) state_d = IDLE;
                                    end
                                end
                            endcase
                        end
                    end
                endcase
            end
        endcase

        if (start) begin
            state_d = start_st;
            idx_d   = start_idx;
            nib_d   = 1'b0;
            ph_d    = PH_SETUP;
            cnt_d   = 32'd0;
            rs_d    = (start_st == LINE1) || (start_st == LINE2);
            dat_d   = item_nib(start_st, start_idx, shadow_q, 1'b1);
            if (start_st == ADDR1) shadow_d = strdata;
        end
    end

    // State registers; reset drops lcd_e asynchronously and restarts power-up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= PWR_WAIT;
            idx_q    <= 4'd0;
            nib_q    <= 1'b0;
            ph_q     <= PH_SETUP;
            cnt_q    <= 32'd0;
            e_q      <= 1'b0;
            rs_q     <= 1'b0;
            dat_q    <= 4'd0;
            shadow_q <= 256'd0;
            pend_q   <= 1'b0;
            fd_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            nib_q    <= nib_d;
            ph_q     <= ph_d;
            cnt_q    <= cnt_d;
            e_q      <= e_d;
            rs_q     <= rs_d;
            dat_q    <= dat_d;
            shadow_q <= shadow_d;
            pend_q   <= pend_d;
            fd_q     <= fd_d;
        end
    end

    assign lcd_e      = e_q;
    assign lcd_rs     = rs_q;
    assign lcd_rw     = 1'b0;
    assign lcd_dat    = dat_q;
    assign frame_done = fd_q;
    assign busy       = !((state_q == IDLE) && !pend_q);

endmodule

// File: doc/lcd_char_driver.md
LCD_CHAR_DRIVER -- requirements
Module: lcd_char_driver

Interface
REQ-001 The module SHALL have parameter POWERUP_CYC, default 750000, setting the power-up wait in clk cycles (15 ms at 50 MHz).
REQ-002 The module SHALL have parameter E_HIGH_CYC, default 12, setting the lcd_e high width in cycles.
REQ-003 The module SHALL have parameter NIB_GAP_CYC, default 50, setting the gap from lcd_e fall to the next nibble setup within one byte.
REQ-004 The module SHALL have parameter CMD_WAIT_CYC, default 2000, setting the post-byte wait; CLR_WAIT_CYC, default 82000, SHALL replace it after command 0x01.
REQ-005 The module SHALL have parameter INIT3_WAIT_CYC, default 205000, setting the wait after the first init nibble.
REQ-006 Port clk SHALL be an input, 1 bit wide: the single clock, with all logic on the rising edge.
REQ-007 Port rst_n SHALL be an input, 1 bit wide: reset, asynchronous and active-low.
REQ-008 Port strdata SHALL be an input, 256 bits wide: 32 ASCII characters; character k (0..31) is strdata[255-8k -: 8].
REQ-009 Port refresh SHALL be an input, 1 bit wide: a synchronous request to rewrite the screen from strdata.
REQ-010 Port lcd_e SHALL be an output, 1 bit wide: the LCD enable strobe.
REQ-011 Port lcd_rs SHALL be an output, 1 bit wide: 0 for a command, 1 for character data.
REQ-012 Port lcd_rw SHALL be an output, 1 bit wide, and SHALL be tied to constant 0 (write only).
REQ-013 Port lcd_dat SHALL be an output, 4 bits wide: the LCD data nibble (DB7..DB4).
REQ-014 Port busy SHALL be an output, 1 bit wide: 1 during init or while a frame is being written.
REQ-015 Port frame_done SHALL be an output, 1 bit wide: a one-cycle pulse when the last character of a frame completes.

Function
REQ-016 The main FSM SHALL use these states: PWR_WAIT, INIT_NIB, INIT_CMD, ADDR1, LINE1, ADDR2, LINE2, IDLE.
REQ-017 PWR_WAIT SHALL count POWERUP_CYC cycles and then go to INIT_NIB.
REQ-018 INIT_NIB SHALL send single nibbles with rs=0, in order:
 - 0x3, then wait INIT3_WAIT_CYC;
 - 0x3, then wait 5000 cycles;
 - 0x3, then wait CMD_WAIT_CYC;
 - 0x2, then wait CMD_WAIT_CYC.
REQ-019 INIT_CMD SHALL send full bytes with rs=0: 0x28, 0x06, 0x0C, then 0x01, each followed by its wait, and then go to ADDR1.
REQ-020 Each byte SHALL be sent as two nibbles: high nibble, NIB_GAP_CYC gap, low nibble, then the post-byte wait.
REQ-021 For each nibble:
 - lcd_rs and lcd_dat SHALL be driven 2 cycles before lcd_e rises;
 - lcd_e SHALL stay high for exactly E_HIGH_CYC cycles;
 - lcd_rs and lcd_dat SHALL be held for at least 2 cycles after lcd_e falls.
REQ-022 ADDR1 SHALL send command 0x80; LINE1 SHALL send characters 0..15 with rs=1.
REQ-023 ADDR2 SHALL send command 0xC0; LINE2 SHALL send characters 16..31 with rs=1; the FSM SHALL then pulse frame_done and go to IDLE.
REQ-024 On entry to ADDR1, strdata SHALL be copied into a 256-bit shadow buffer; characters SHALL come only from the shadow, so a frame never tears.
REQ-025 A refresh seen in IDLE SHALL start ADDR1 on the next cycle; init SHALL NOT be repeated.
REQ-026 A refresh seen outside IDLE SHALL set a pending flag.
 - Multiple requests SHALL merge into one.
 - The flag SHALL be consumed when the current frame ends: the FSM goes directly to ADDR1 and frame_done still pulses.
REQ-027 The first frame after init SHALL be written without waiting for a refresh.
REQ-028 busy SHALL be 0 only in IDLE with no refresh pending.
REQ-029 The character and nibble counters SHALL never wrap past 15 or 1; the end of a line is decided by the counter, not by the data.

Reset
REQ-030 While rst_n=0, the outputs SHALL be: lcd_e=0, lcd_rs=0, lcd_rw=0, lcd_dat=0, busy=1, frame_done=0.
REQ-031 While rst_n=0, the FSM SHALL be in PWR_WAIT with all counters, the shadow buffer and the pending flag cleared.
REQ-032 Reset asserted mid-byte SHALL drop lcd_e immediately; on release, the full power-up and init sequence SHALL restart.

Verification
(Bench parameters: POWERUP_CYC=20, E_HIGH_CYC=2, NIB_GAP_CYC=3, CMD_WAIT_CYC=5, CLR_WAIT_CYC=9, INIT3_WAIT_CYC=7; a bus-monitor model decodes nibbles on lcd_e fall.)
REQ-033 Release rst_n -> first lcd_e rise after at least 20 cycles; the nibble stream SHALL be 3,3,3,2, then 2,8 / 0,6 / 0,C / 0,1.
REQ-034 Set strdata to "PC=000 00000000 " + "R00=0000001F    " -> the monitor SHALL see 0x80, 16 line-1 bytes with rs=1, 0xC0, then 16 line-2 bytes; frame_done SHALL pulse once and busy SHALL fall.
REQ-035 Change strdata during LINE1 -> the displayed frame SHALL show the old data only; no new frame starts without a refresh.
REQ-036 Pulse refresh 3 times during LINE2 -> exactly one extra frame SHALL follow, carrying the strdata sampled at its ADDR1.
REQ-037 Assert rst_n=0 while lcd_e is high -> lcd_e=0 in the same cycle; after release, the full init sequence SHALL repeat.
REQ-038 Timing check on every nibble -> lcd_e high exactly 2 cycles, setup of at least 2 cycles, hold of at least 2 cycles, and lcd_rw=0 at all times.
